// File: rtl/apb_uart_pkg.sv
// Shared constants and types for the APB UART register block.
package apb_uart_pkg;

    localparam int unsigned CTRL_W = 7;
    localparam int unsigned CD_W   = 13;

    // Register select values, taken from PADDR[3:2]
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_CD     = 2'd2;
    localparam logic [1:0] REG_DATA   = 2'd3;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_RX_EMPTY = 3;
    localparam int unsigned ST_TX_OVR   = 4;
    localparam int unsigned ST_RX_OVR   = 5;

    localparam int unsigned CT_TX_EN  = 0;
    localparam int unsigned CT_RX_EN  = 1;
    localparam int unsigned CT_IE_RX  = 2;
    localparam int unsigned CT_IE_TX  = 3;
    localparam int unsigned CT_IE_ERR = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } access_state_e;

endpackage

// File: rtl/apb_uart_csr_if.sv
// APB3 slave bus bundle for the UART register block.
interface apb_uart_csr_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_uart_csr_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign do_rd = pop & ~empty;
    assign do_wr = push & (~full | do_rd);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/apb_uart_csr.sv
// APB3 CSR block for the UART: CTRL/CD registers, TX/RX FIFOs, sticky status, irq.
module apb_uart_csr
    import apb_uart_pkg::*;
#(
    parameter int unsigned    DATA_W   = 8,
    parameter int unsigned    TX_DEPTH = 8,
    parameter int unsigned    RX_DEPTH = 8,
    parameter int unsigned    WAIT_MAX = 15,
    parameter logic [CD_W-1:0] CD_RESET = 13'd27
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_uart_csr_if.slave     apb,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CD_W-1:0]   cd_o,
    output logic              irq
);
    localparam int unsigned SC_W  = $clog2(WAIT_MAX + 1);
    localparam int unsigned TXC_W = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RXC_W = $clog2(RX_DEPTH) + 1;

    access_state_e     state, state_nxt;
    logic [SC_W-1:0]   stall_cnt;
    logic [CTRL_W-1:0] ctrl;
    logic [CD_W-1:0]   cd;
    logic              tx_ovr, rx_ovr;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [TXC_W-1:0]  tx_count;
    logic [RXC_W-1:0]  rx_count;
    logic [DATA_W-1:0] rx_head;
    logic              access, is_write, is_data;
    logic [1:0]        reg_sel;
    logic              ready_c, err_c;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic              tx_ovr_set, rx_ovr_set;
    logic              wr_done, w1c;
    logic [31:0]       rdata_c;
    logic              unused_bits;

    // Reset also masks the access phase so PREADY drops the moment PRESETn falls.
    assign access   = apb.PSEL & apb.PENABLE & PRESETn;
    assign is_write = apb.PWRITE;
    assign reg_sel  = apb.PADDR[3:2];
    assign is_data  = (reg_sel == REG_DATA);

    assign tx_valid   = ~tx_empty & ctrl[CT_TX_EN];
    assign tx_pop     = tx_valid & tx_ready;
    assign rx_push    = rx_valid & ctrl[CT_RX_EN];
    assign rx_ovr_set = rx_push & rx_full & ~rx_pop;

    assign wr_done = ready_c & is_write & ~err_c;
    assign w1c     = wr_done & (reg_sel == REG_STATUS);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= (state == STALL) ? stall_cnt + SC_W'(1) : '0;
        end
    end

    // Access FSM: zero-wait for everything except a DATA write to a full TX FIFO.
    always_comb begin
        state_nxt  = state;
        ready_c    = 1'b0;
        err_c      = 1'b0;
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        tx_ovr_set = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (is_write && is_data && tx_full) begin
                        state_nxt = STALL;
                    end else begin
                        ready_c = 1'b1;
                        if (is_write && is_data) tx_push = 1'b1;
                        if (!is_write && is_data) begin
                            if (rx_empty) err_c  = 1'b1;
                            else          rx_pop = 1'b1;
                        end
                    end
                end
            end
            STALL: begin
                if (access) begin
                    if (!tx_full) begin
                        ready_c   = 1'b1;
                        tx_push   = 1'b1;
                        state_nxt = IDLE;
                    end else if (stall_cnt == SC_W'(WAIT_MAX - 1)) begin
                        ready_c    = 1'b1;
                        err_c      = 1'b1;
                        tx_ovr_set = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read mux; zero unless a read completes this cycle.
    always_comb begin
        rdata_c = '0;
        if (ready_c && !is_write) begin
            case (reg_sel)
                REG_STATUS: begin
                    rdata_c[ST_TX_FULL]  = tx_full;
                    rdata_c[ST_TX_EMPTY] = tx_empty;
                    rdata_c[ST_RX_FULL]  = rx_full;
                    rdata_c[ST_RX_EMPTY] = rx_empty;
                    rdata_c[ST_TX_OVR]   = tx_ovr;
                    rdata_c[ST_RX_OVR]   = rx_ovr;
                end
                REG_CTRL: rdata_c[CTRL_W-1:0] = ctrl;
                REG_CD:   rdata_c[CD_W-1:0]   = cd;
                default:  if (!rx_empty) rdata_c[DATA_W-1:0] = rx_head;
            endcase
        end
    end

    // Registers and sticky flags; a new overrun wins over a simultaneous clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl   <= '0;
            cd     <= CD_RESET;
            tx_ovr <= 1'b0;
            rx_ovr <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_done && reg_sel == REG_CTRL) ctrl <= apb.PWDATA[CTRL_W-1:0];
            if (wr_done && reg_sel == REG_CD)   cd   <= apb.PWDATA[CD_W-1:0];
            tx_ovr <= tx_ovr_set | (tx_ovr & ~(w1c & apb.PWDATA[ST_TX_OVR]));
            rx_ovr <= rx_ovr_set | (rx_ovr & ~(w1c & apb.PWDATA[ST_RX_OVR]));
            irq    <= (ctrl[CT_IE_RX] & ~rx_empty) | (ctrl[CT_IE_TX] & tx_empty) |
                      (ctrl[CT_IE_ERR] & (tx_ovr | rx_ovr));
        end
    end

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (apb.PWDATA[DATA_W-1:0]),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign apb.PREADY  = ready_c;
    assign apb.PSLVERR = err_c;
    assign apb.PRDATA  = rdata_c;
    assign ctrl_o      = ctrl;
    assign cd_o        = cd;

    assign unused_bits = ^{apb.PADDR[7:4], apb.PADDR[1:0], apb.PWDATA[31:13], tx_count, rx_count};

endmodule
